// File: rtl/iobuf_bank_reg.sv
// iobuf_bank_reg
// Registered bidirectional pad bank. Drive data and output enable come
// from flops. After the bus is released, a programmable number of Hi-Z
// cycles must pass before it can be driven again. Pad values return to
// the core through a per-bit synchroniser.
//
// Parameters:
//   WIDTH        pad bits (1..32)
//   TURNAROUND   forced Hi-Z cycles after a release (0..15)
//   SYNC_STAGES  synchroniser depth (1..4)
//   OPEN_DRAIN   1: only zeros are driven, ones are left to the pull-ups
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   oe_req   level request to drive the bus
//   dout     data to drive, captured every cycle the next state is DRIVE
//   ready    high in IDLE or DRIVE (a new drive may start)
//   driving  registered output enable
//   din      synchronised pad value
//   io       pads
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | pads Hi-Z, a request starts a drive on the next edge
// DRIVE | pads driven from dout_q, reloaded each cycle
// GAP   | pads Hi-Z, cnt counts down the turnaround, requests ignored
module iobuf_bank_reg #(
    parameter int WIDTH       = 8,
    parameter int TURNAROUND  = 2,
    parameter int SYNC_STAGES = 2,
    parameter bit OPEN_DRAIN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             oe_req,
    input  logic [WIDTH-1:0] dout,
    output logic             ready,
    output logic             driving,
    output logic [WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0] io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Terminal count is 0, so a gap of N cycles loads N-1.
    localparam logic [3:0] CNT_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] dout_q;
    logic             driving_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            dout_q    <= '0;
            driving_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            driving_q <= (state_d == DRIVE);
            if (state_d == DRIVE) begin
                dout_q <= dout;
            end
            if (state_q == DRIVE && state_d == GAP) begin
                cnt_q <= CNT_LOAD;
            end else if (state_q == GAP && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (oe_req) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (!oe_req) begin
                    state_d = (TURNAROUND == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready   = (state_q != GAP);
        driving = driving_q;
    end

    // Pads follow the enable flop directly, so an async reset releases
    // them without waiting for a clock edge.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        if (OPEN_DRAIN) begin : g_od
            assign io[i] = (driving_q && !dout_q[i]) ? 1'b0 : 1'bz;
        end else begin : g_pp
            assign io[i] = driving_q ? dout_q[i] : 1'bz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= io;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign din = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_iobuf_bank_reg.sv
module tb_iobuf_bank_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       oe_req = 1'b0;
    logic [7:0] dout = 8'h00;
    logic       ext_en = 1'b0;
    logic [7:0] ext_val = 8'h00;

    // External pull-ups on every pad group, so a released pad reads 1.
    tri1 [7:0] io_a;
    tri1 [7:0] io_b;
    tri1 [7:0] io_c;

    logic       rdy_a, drv_a, rdy_b, drv_b, rdy_c, drv_c;
    logic [7:0] din_a, din_b, din_c;

    assign io_a = ext_en ? ext_val : 8'hzz;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // A: push-pull, gap 2.  B: push-pull, no gap.  C: open drain, gap 2.
    iobuf_bank_reg #(.WIDTH(8), .TURNAROUND(2), .SYNC_STAGES(2), .OPEN_DRAIN(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .oe_req(oe_req), .dout(dout),
        .ready(rdy_a), .driving(drv_a), .din(din_a), .io(io_a)
    );
    iobuf_bank_reg #(.WIDTH(8), .TURNAROUND(0), .SYNC_STAGES(2), .OPEN_DRAIN(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .oe_req(oe_req), .dout(dout),
        .ready(rdy_b), .driving(drv_b), .din(din_b), .io(io_b)
    );
    iobuf_bank_reg #(.WIDTH(8), .TURNAROUND(2), .SYNC_STAGES(2), .OPEN_DRAIN(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .oe_req(oe_req), .dout(dout),
        .ready(rdy_c), .driving(drv_c), .din(din_c), .io(io_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        oe_req  = 1'b0;
        dout    = 8'h00;
        ext_en  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       oe;
        logic [7:0] dv;
        logic       a_drv;
        logic       a_rdy;
        logic [7:0] a_io;
        logic [7:0] a_din;
        logic       b_drv;
        logic       b_rdy;
        logic [7:0] b_io;
        logic [7:0] b_din;
    } vec_t;

    vec_t tbl [9];

    // Reference model state, indexed by instance (A, B, C).
    localparam int NRAND = 400;
    int         m_gap_len [3] = '{2, 0, 2};
    bit         m_drv [3];
    logic [7:0] m_data [3];
    int         m_gap [3];
    logic [7:0] m_pad [3][0:NRAND];

    initial begin
        tbl[0] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b1, 8'h3C, 8'h00};
        tbl[1] = '{1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 8'hFF, 1'b1, 1'b1, 8'hC3, 8'hFF};
        tbl[2] = '{1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 8'h3C, 1'b1, 1'b1, 8'hC3, 8'h3C};
        tbl[3] = '{1'b1, 8'hC3, 1'b1, 1'b1, 8'hC3, 8'hC3, 1'b1, 1'b1, 8'hC3, 8'hC3};
        tbl[4] = '{1'b0, 8'hC3, 1'b0, 1'b0, 8'hFF, 8'hC3, 1'b0, 1'b1, 8'hFF, 8'hC3};
        tbl[5] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'hFF, 8'hC3, 1'b1, 1'b1, 8'h11, 8'hC3};
        tbl[6] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h22, 8'hFF};
        tbl[7] = '{1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 8'hFF, 1'b1, 1'b1, 8'h44, 8'h11};
        tbl[8] = '{1'b0, 8'h44, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 8'h22};

        // Reset state while rst_n is held from time zero.
        #1;
        chk("rst drv_a", drv_a, 1'b0);
        chk("rst rdy_a", rdy_a, 1'b1);
        chk("rst din_a", din_a, 8'h00);
        chk("rst io_a", io_a, 8'hFF);

        // Reset dropped in the middle of a drive.
        do_reset();
        oe_req = 1'b1;
        dout   = 8'hA5;
        @(posedge clk);
        #2;
        chk("pre-rst io_a", io_a, 8'hA5);
        chk("pre-rst drv_a", drv_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async rst io_a", io_a, 8'hFF);
        chk("async rst io_c", io_c, 8'hFF);
        chk("async rst drv_a", drv_a, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rst held din_a", din_a, 8'h00);
        oe_req = 1'b0;
        rst_n  = 1'b1;
        #1;
        chk("post-rst rdy_a", rdy_a, 1'b1);

        // Basic drive, turnaround gap and zero-gap instance, edge by edge.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            oe_req = tbl[i].oe;
            dout   = tbl[i].dv;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d a_drv", i + 1), drv_a, tbl[i].a_drv);
            chk($sformatf("tbl%0d a_rdy", i + 1), rdy_a, tbl[i].a_rdy);
            chk($sformatf("tbl%0d a_io", i + 1), io_a, tbl[i].a_io);
            chk($sformatf("tbl%0d a_din", i + 1), din_a, tbl[i].a_din);
            chk($sformatf("tbl%0d b_drv", i + 1), drv_b, tbl[i].b_drv);
            chk($sformatf("tbl%0d b_rdy", i + 1), rdy_b, tbl[i].b_rdy);
            chk($sformatf("tbl%0d b_io", i + 1), io_b, tbl[i].b_io);
            chk($sformatf("tbl%0d b_din", i + 1), din_b, tbl[i].b_din);
            chk($sformatf("tbl%0d c_io", i + 1), io_c, tbl[i].a_io);
        end

        // Open drain: ones left to the pull-ups, zeros driven.
        do_reset();
        oe_req = 1'b1;
        dout   = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        chk("od io_c", io_c, 8'hF0);
        chk("od io_c known", $isunknown(io_c), 1'b0);
        chk("od drv_c", drv_c, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("od din_c early", din_c, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        chk("od din_c", din_c, 8'hF0);

        // External input on an idle bank.
        do_reset();
        @(posedge clk);
        @(negedge clk);
        ext_en  = 1'b1;
        ext_val = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        chk("ext io_a", io_a, 8'h5A);
        chk("ext io_a known", $isunknown(io_a), 1'b0);
        chk("ext din_a early", din_a, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        chk("ext din_a", din_a, 8'h5A);
        ext_en = 1'b0;

        // Random requests against a cycle-level behavioural model.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            m_drv[k]    = 1'b0;
            m_data[k]   = 8'h00;
            m_gap[k]    = 0;
            m_pad[k][0] = 8'hFF;
        end
        for (int n = 1; n <= NRAND; n++) begin
            oe_req = ($urandom % 4) != 0;
            dout   = 8'($urandom);
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                if (m_drv[k]) begin
                    if (oe_req) begin
                        m_data[k] = dout;
                    end else begin
                        m_drv[k] = 1'b0;
                        m_gap[k] = m_gap_len[k];
                    end
                end else if (m_gap[k] > 0) begin
                    m_gap[k] = m_gap[k] - 1;
                end else if (oe_req) begin
                    m_drv[k]  = 1'b1;
                    m_data[k] = dout;
                end
                m_pad[k][n] = m_drv[k] ? m_data[k] : 8'hFF;
            end
            @(negedge clk);
            begin
                logic [7:0] exp_din [3];
                for (int k = 0; k < 3; k++) begin
                    exp_din[k] = (n >= 2) ? m_pad[k][n-2] : 8'h00;
                end
                chk($sformatf("rnd%0d a_drv", n), drv_a, m_drv[0]);
                chk($sformatf("rnd%0d a_rdy", n), rdy_a, m_gap[0] == 0);
                chk($sformatf("rnd%0d a_io", n), io_a, m_pad[0][n]);
                chk($sformatf("rnd%0d a_din", n), din_a, exp_din[0]);
                chk($sformatf("rnd%0d b_drv", n), drv_b, m_drv[1]);
                chk($sformatf("rnd%0d b_rdy", n), rdy_b, m_gap[1] == 0);
                chk($sformatf("rnd%0d b_io", n), io_b, m_pad[1][n]);
                chk($sformatf("rnd%0d b_din", n), din_b, exp_din[1]);
                chk($sformatf("rnd%0d c_drv", n), drv_c, m_drv[2]);
                chk($sformatf("rnd%0d c_rdy", n), rdy_c, m_gap[2] == 0);
                chk($sformatf("rnd%0d c_io", n), io_c, m_pad[2][n]);
                chk($sformatf("rnd%0d c_din", n), din_c, exp_din[2]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
